// File: rtl/alu_checker.sv
// Passive ALU result checker: recomputes the expected result of each observed
// transaction over a 2-stage pipeline, counts pass/fail and captures the first failure.
module alu_checker #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] z,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_flag,
  output logic [3:0]       err_op,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic [WIDTH-1:0] err_z,
  output logic [WIDTH-1:0] err_exp,
  output logic             halted
);

  localparam int unsigned OP_W    = 4;
  localparam bit          STOP_EN = (STOP_ON_FAIL != 0);

  localparam logic [OP_W-1:0] OP_AND = 4'd0;
  localparam logic [OP_W-1:0] OP_OR  = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB = 4'd6;
  localparam logic [OP_W-1:0] OP_SLT = 4'd7;
  localparam logic [OP_W-1:0] OP_NOR = 4'd12;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             accept_c;
  logic             retire_fail_c;

  logic             s1_valid;
  logic [OP_W-1:0]  s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, s1_z;

  logic             s2_valid;
  logic             s2_match;
  logic [OP_W-1:0]  s2_op;
  logic [WIDTH-1:0] s2_a, s2_b, s2_z, s2_exp;

  logic [WIDTH-1:0] exp_c;
  logic             legal_c;
  logic             match_c;

  assign accept_c      = in_valid & in_ready;
  assign retire_fail_c = s2_valid & ~s2_match;

  // Reference model of the ALU; unknown op codes never match.
  always_comb begin
    exp_c   = '0;
    legal_c = 1'b1;
    case (s1_op)
      OP_AND:  exp_c = s1_a & s1_b;
      OP_OR:   exp_c = s1_a | s1_b;
      OP_ADD:  exp_c = s1_a + s1_b;
      OP_SUB:  exp_c = s1_a - s1_b;
      OP_SLT:  exp_c = WIDTH'($signed(s1_a) < $signed(s1_b));
      OP_NOR:  exp_c = ~(s1_a | s1_b);
      default: legal_c = 1'b0;
    endcase
    match_c = legal_c && (exp_c == s1_z);
  end

  // FSM next state; clear overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = RUN;
      RUN:     if (retire_fail_c && STOP_EN) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // in_ready and halted are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != HALT);
      halted   <= (state_nxt == HALT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_z     <= '0;
      s2_valid <= 1'b0;
      s2_match <= 1'b0;
      s2_op    <= '0;
      s2_a     <= '0;
      s2_b     <= '0;
      s2_z     <= '0;
      s2_exp   <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_op <= op;
        s1_a  <= a;
        s1_b  <= b;
        s1_z  <= z;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_match <= match_c;
        s2_op    <= s1_op;
        s2_a     <= s1_a;
        s2_b     <= s1_b;
        s2_z     <= s1_z;
        s2_exp   <= exp_c;
      end
    end
  end

  // Retire: saturating counters and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_flag <= 1'b0;
      err_op   <= '0;
      err_a    <= '0;
      err_b    <= '0;
      err_z    <= '0;
      err_exp  <= '0;
    end else if (clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_flag <= 1'b0;
      err_op   <= '0;
      err_a    <= '0;
      err_b    <= '0;
      err_z    <= '0;
      err_exp  <= '0;
    end else if (s2_valid) begin
      if (s2_match) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
        if (retire_fail_c && !err_flag) begin
          err_flag <= 1'b1;
          err_op   <= s2_op;
          err_a    <= s2_a;
          err_b    <= s2_b;
          err_z    <= s2_z;
          err_exp  <= s2_exp;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_checker.sv
// Bench for alu_checker: table-driven vectors scored through a latency-aware queue,
// plus directed halt, saturation and asynchronous reset sequences.
module tb_alu_checker;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  logic clear;
  logic [3:0] op;
  logic [W-1:0] a, b, z;
  logic in_valid0, in_valid1;

  logic in_ready0, err_flag0, halted0;
  logic [15:0] pass_cnt0, fail_cnt0;
  logic [3:0] err_op0;
  logic [W-1:0] err_a0, err_b0, err_z0, err_exp0;

  logic in_ready1, err_flag1, halted1;
  logic [1:0] pass_cnt1, fail_cnt1;
  logic [3:0] err_op1;
  logic [W-1:0] err_a1, err_b1, err_z1, err_exp1;

  alu_checker #(.WIDTH(W), .CNT_W(16), .STOP_ON_FAIL(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .op(op), .a(a), .b(b), .z(z), .clear(clear),
    .pass_cnt(pass_cnt0), .fail_cnt(fail_cnt0), .err_flag(err_flag0),
    .err_op(err_op0), .err_a(err_a0), .err_b(err_b0), .err_z(err_z0),
    .err_exp(err_exp0), .halted(halted0)
  );

  alu_checker #(.WIDTH(W), .CNT_W(2), .STOP_ON_FAIL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op), .a(a), .b(b), .z(z), .clear(clear),
    .pass_cnt(pass_cnt1), .fail_cnt(fail_cnt1), .err_flag(err_flag1),
    .err_op(err_op1), .err_a(err_a1), .err_b(err_b1), .err_z(err_z1),
    .err_exp(err_exp1), .halted(halted1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
    bit           exp_pass;
  } vec_t;

  typedef struct {
    int due;
    bit pass;
  } sb_t;

  vec_t vecs[13];
  sb_t  sbq[$];
  sb_t  mon_e;
  bit   sb_en = 1'b0;
  int   prev_tot = 0;
  int   exp_p = 0;
  int   exp_f = 0;
  int   mon_tot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every change of u0's total count must correspond to the oldest queued transaction.
  always @(negedge clk) begin
    if (sb_en) begin
      mon_tot = int'(pass_cnt0) + int'(fail_cnt0);
      if (mon_tot != prev_tot) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected_retire: got total %0d, expected no retire", mon_tot);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_e.pass) exp_p++;
          else exp_f++;
          chk("sb_latency_cycle", 32'(cyc), 32'(mon_e.due));
          chk("sb_pass_cnt", 32'(pass_cnt0), 32'(exp_p));
          chk("sb_fail_cnt", 32'(fail_cnt0), 32'(exp_f));
        end
        prev_tot = mon_tot;
      end
    end
  end

  task automatic sb_start();
    sbq.delete();
    prev_tot = 0;
    exp_p    = 0;
    exp_f    = 0;
    sb_en    = 1'b1;
  endtask

  // Called at a falling edge; accept happens on the next rising edge, counters two edges later.
  task automatic drive0(input vec_t v);
    op = v.op; a = v.a; b = v.b; z = v.z;
    in_valid0 = 1'b1;
    sbq.push_back('{due: cyc + 3, pass: v.exp_pass});
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  8'h15, 8'h03, 8'h01, 1'b1};
    vecs[1]  = '{4'd2,  8'h05, 8'hFC, 8'h01, 1'b1};
    vecs[2]  = '{4'd6,  8'h09, 8'h0A, 8'hFF, 1'b1};
    vecs[3]  = '{4'd7,  8'h01, 8'h03, 8'h01, 1'b1};
    vecs[4]  = '{4'd7,  8'h06, 8'h05, 8'h00, 1'b1};
    vecs[5]  = '{4'd12, 8'h01, 8'h03, 8'hFC, 1'b1};
    vecs[6]  = '{4'd1,  8'hF0, 8'h0F, 8'hFF, 1'b1};
    vecs[7]  = '{4'd2,  8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[8]  = '{4'd7,  8'h80, 8'h7F, 8'h01, 1'b1};
    vecs[9]  = '{4'd7,  8'h7F, 8'h80, 8'h00, 1'b1};
    vecs[10] = '{4'd1,  8'h02, 8'h05, 8'h05, 1'b0};
    vecs[11] = '{4'd2,  8'h02, 8'h05, 8'h00, 1'b0};
    vecs[12] = '{4'd3,  8'h00, 8'h00, 8'h00, 1'b0};

    clear = 1'b0; op = '0; a = '0; b = '0; z = '0;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pass_cnt0", 32'(pass_cnt0), 32'd0);
    chk("rst_fail_cnt0", 32'(fail_cnt0), 32'd0);
    chk("rst_err_flag0", 32'(err_flag0), 32'd0);
    chk("rst_err_exp0",  32'(err_exp0),  32'd0);
    chk("rst_in_ready0", 32'(in_ready0), 32'd1);
    chk("rst_halted1",   32'(halted1),   32'd0);
    chk("rst_in_ready1", 32'(in_ready1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // All-pass vectors, back to back.
    do_clear();
    sb_start();
    for (int i = 0; i < 10; i++) drive0(vecs[i]);
    in_valid0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pass_drain", 32'(sbq.size()), 32'd0);
    chk("pass_total", 32'(pass_cnt0), 32'd10);
    chk("pass_fail_cnt", 32'(fail_cnt0), 32'd0);
    chk("pass_err_flag", 32'(err_flag0), 32'd0);
    chk("pass_in_ready", 32'(in_ready0), 32'd1);

    // Failures without halting; first one is captured.
    sb_en = 1'b0;
    do_clear();
    sb_start();
    for (int i = 10; i < 13; i++) drive0(vecs[i]);
    in_valid0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mis_drain", 32'(sbq.size()), 32'd0);
    chk("mis_fail_cnt", 32'(fail_cnt0), 32'd3);
    chk("mis_pass_cnt", 32'(pass_cnt0), 32'd0);
    chk("mis_err_flag", 32'(err_flag0), 32'd1);
    chk("mis_err_op",   32'(err_op0),   32'd1);
    chk("mis_err_a",    32'(err_a0),    32'd2);
    chk("mis_err_b",    32'(err_b0),    32'd5);
    chk("mis_err_z",    32'(err_z0),    32'h05);
    chk("mis_err_exp",  32'(err_exp0),  32'h07);
    chk("mis_halted0",  32'(halted0),   32'd0);
    chk("mis_in_ready0", 32'(in_ready0), 32'd1);

    sb_en = 1'b0;
    do_clear();
    chk("clr_pass_cnt", 32'(pass_cnt0), 32'd0);
    chk("clr_fail_cnt", 32'(fail_cnt0), 32'd0);
    chk("clr_err_flag", 32'(err_flag0), 32'd0);
    chk("clr_err_op",   32'(err_op0),   32'd0);
    chk("clr_err_exp",  32'(err_exp0),  32'd0);

    // Halt: illegal op, then one pass in the following cycle.
    op = 4'd3; a = 8'h01; b = 8'h01; z = 8'h00; in_valid1 = 1'b1;
    @(negedge clk);
    op = 4'd0; a = 8'h03; b = 8'h01; z = 8'h01;
    @(negedge clk);
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("halt_halted",   32'(halted1),   32'd1);
    chk("halt_in_ready", 32'(in_ready1), 32'd0);
    chk("halt_fail_cnt", 32'(fail_cnt1), 32'd1);
    chk("halt_pass_pre", 32'(pass_cnt1), 32'd0);
    in_valid1 = 1'b1;
    repeat (4) @(negedge clk);
    chk("halt_inflight_pass", 32'(pass_cnt1), 32'd1);
    chk("halt_held_fail_cnt", 32'(fail_cnt1), 32'd1);
    chk("halt_sticky",   32'(halted1),   32'd1);
    chk("halt_err_op",   32'(err_op1),   32'd3);
    chk("halt_err_exp",  32'(err_exp1),  32'd0);
    in_valid1 = 1'b0;
    do_clear();
    chk("halt_clr_halted",   32'(halted1),   32'd0);
    chk("halt_clr_in_ready", 32'(in_ready1), 32'd1);
    chk("halt_clr_pass",     32'(pass_cnt1), 32'd0);
    chk("halt_clr_fail",     32'(fail_cnt1), 32'd0);
    chk("halt_clr_err_flag", 32'(err_flag1), 32'd0);

    // Saturation of a 2-bit counter.
    op = 4'd0; a = 8'h03; b = 8'h01; z = 8'h01; in_valid1 = 1'b1;
    repeat (5) @(negedge clk);
    in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_pass_cnt", 32'(pass_cnt1), 32'd3);
    chk("sat_fail_cnt", 32'(fail_cnt1), 32'd0);
    op = 4'd3; a = 8'h11; b = 8'h22; z = 8'h33; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_halted", 32'(halted1), 32'd1);
    chk("sat_err_z",  32'(err_z1),  32'h33);

    // Async reset mid-cycle with a u0 transaction in flight, valid held across it.
    op = 4'd0; a = 8'h03; b = 8'h01; z = 8'h01; in_valid0 = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pass1",     32'(pass_cnt1), 32'd0);
    chk("arst_fail1",     32'(fail_cnt1), 32'd0);
    chk("arst_err_flag1", 32'(err_flag1), 32'd0);
    chk("arst_err_op1",   32'(err_op1),   32'd0);
    chk("arst_err_a1",    32'(err_a1),    32'd0);
    chk("arst_err_b1",    32'(err_b1),    32'd0);
    chk("arst_err_z1",    32'(err_z1),    32'd0);
    chk("arst_err_exp1",  32'(err_exp1),  32'd0);
    chk("arst_halted1",   32'(halted1),   32'd0);
    chk("arst_in_ready1", 32'(in_ready1), 32'd1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_drop_reaccept", 32'(pass_cnt0), 32'd1);
    chk("arst_fail0", 32'(fail_cnt0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
